// File: rtl/obi_mem_slave.sv
// obi_mem_slave: OBI memory slave with byte-enable writes, fixed-latency in-order responses,
// optional LFSR grant backpressure and a backdoor preload port.
module obi_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY = 1,
  parameter int STALL_EN = 0,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  input  logic                    load_en_i,
  input  logic [ADDR_WIDTH-1:0]   load_addr_i,
  input  logic [DATA_WIDTH-1:0]   load_data_i
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW = ADDR_WIDTH - OFF;
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] d [LATENCY];
  logic [LATENCY-1:0] v, e;
  logic [7:0] lfsr;
  logic [IW-1:0] idx, load_idx;
  logic stall, in_rng, load_rng, unused;
  assign unused = ^{addr_i, load_addr_i};
  assign idx = addr_i[ADDR_WIDTH-1:OFF];
  assign load_idx = load_addr_i[ADDR_WIDTH-1:OFF];
  assign in_rng = idx < IW'(DEPTH_WORDS);
  assign load_rng = load_idx < IW'(DEPTH_WORDS);
  assign stall = (STALL_EN != 0) && lfsr[0];
  assign gnt_o = req_i & ~load_en_i & ~stall & ~rst;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  // Memory is deliberately outside reset so preloads survive and apply during rst.
  always_ff @(posedge clk) begin
    if (load_en_i && load_rng) mem[load_idx[AW-1:0]] <= load_data_i;
    else if (gnt_o && we_i && in_rng)
      for (int b = 0; b < NB; b++)
        if (be_i[b]) mem[idx[AW-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
  end
  // Response shift register; stage 0 captures the read at the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= gnt_o;
      e[0] <= gnt_o & ~in_rng;
      d[0] <= (gnt_o && !we_i && in_rng) ? mem[idx[AW-1:0]] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  assign rvalid_o = v[LATENCY-1] & ~rst;
  assign err_o = e[LATENCY-1] & ~rst;
  assign rdata_o = rst ? '0 : d[LATENCY-1];
endmodule

// File: doc/obi_mem_slave.md
OBI_MEM_SLAVE -- requirements
Module: obi_mem_slave

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, bus data width (multiple of 8).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL provide parameter DEPTH_WORDS, default 64, number of DATA_WIDTH words stored.
REQ-004 SHALL provide parameter LATENCY, default 1, accept-to-rvalid cycles, legal range 1..4.
REQ-005 SHALL provide parameter STALL_EN, default 0, 1 enables pseudo-random grant backpressure.
REQ-006 SHALL provide parameter LFSR_SEED, default 8'hA5, nonzero stall LFSR reset value.
REQ-007 SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-008 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL provide port req_i, input, 1, transaction request.
REQ-010 SHALL provide port addr_i, input, ADDR_WIDTH, byte address.
REQ-011 SHALL provide port we_i, input, 1, 1 = write, 0 = read.
REQ-012 SHALL provide port be_i, input, DATA_WIDTH/8, write byte enables.
REQ-013 SHALL provide port wdata_i, input, DATA_WIDTH, write data.
REQ-014 SHALL provide port gnt_o, output, 1, request accepted this cycle.
REQ-015 SHALL provide port rvalid_o, output, 1, response valid.
REQ-016 SHALL provide port rdata_o, output, DATA_WIDTH, read response data.
REQ-017 SHALL provide port err_o, output, 1, response error flag, qualified by rvalid_o.
REQ-018 SHALL provide port load_en_i, input, 1, backdoor preload strobe.
REQ-019 SHALL provide port load_addr_i, input, ADDR_WIDTH, preload byte address.
REQ-020 SHALL provide port load_data_i, input, DATA_WIDTH, preload full word.

Function
REQ-021 Word index SHALL be addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
REQ-022 gnt_o SHALL be combinational: req_i & ~load_en_i & ~stall & ~rst.
REQ-023 stall SHALL be 0 when STALL_EN=0, else bit 0 of an 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing every cycle.
REQ-024 Accept SHALL occur in a cycle with req_i & gnt_o; at most one accept per cycle.
REQ-025 Read accept SHALL sample memory at the accept edge; rdata_o SHALL carry that value.
REQ-026 Write accept SHALL update only bytes with be_i set at the accept edge; be_i = 0 writes nothing.
REQ-027 Every accept SHALL produce exactly one response: rvalid_o high for one cycle, LATENCY cycles after the accept edge.
REQ-028 Responses SHALL return in accept order; up to LATENCY transactions outstanding; back-to-back accepts yield back-to-back responses.
REQ-029 Write response SHALL have rdata_o = 0, err_o = 0.
REQ-030 Word index >= DEPTH_WORDS SHALL give err_o = 1, rdata_o = 0, no memory change.
REQ-031 A read accepted the cycle after a write to the same word SHALL return the written data.
REQ-032 Load with load_en_i SHALL write load_data_i to its word at the edge; out-of-range load ignored; gnt_o held low that cycle.
REQ-033 When rvalid_o = 0, rdata_o and err_o SHALL be 0.
REQ-034 With LATENCY=1, STALL_EN=0, behaviour SHALL be gnt = req and rdata/rvalid one cycle after req.

Reset
REQ-035 While rst = 1: rvalid_o, err_o, rdata_o = 0; pipeline cleared; LFSR = LFSR_SEED; gnt_o = 0.
REQ-036 Responses in flight when rst asserts SHALL be discarded and never emitted.
REQ-037 Memory contents SHALL not be cleared by reset; loads during reset SHALL take effect.

Verification
REQ-038 LATENCY=1: load word 3 = 32'h00F00293, read addr 12 -> gnt same cycle, rvalid=1, rdata=32'h00F00293 next cycle.
REQ-039 LATENCY=3: reads addr 0,4,8 on consecutive cycles -> rvalid on cycles 3,4,5 after first accept, data in order.
REQ-040 Write addr 8, be=4'b0101, wdata=32'hAABBCCDD over 32'h11223344, then read addr 8 -> rdata=32'h11BB33DD.
REQ-041 Read addr 256 with DEPTH_WORDS=64 -> rvalid=1, err=1, rdata=0; memory unchanged.
REQ-042 STALL_EN=1, hold req for 20 cycles -> gnt matches LFSR bit0 model from seed 8'hA5; responses equal accepts.
REQ-043 LATENCY=2: accept read, assert rst next cycle -> no rvalid ever emitted for it; gnt_o=0 during reset.
